wasca_spi_sync_ctrl: RTL

//  Avalon-MM controller for the SPI sync strobe from the cartridge side.

---
 rtl/wasca_spi_sync_ctrl_if.sv | 21 ++
 rtl/wasca_spi_sync_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/wasca_spi_sync_ctrl_if.sv
// Avalon-MM slave bus plus the SPI sync pin and interrupt for wasca_spi_sync_ctrl.
// Valid/ready: no backpressure; a write is accepted in every cycle where chipselect & ~write_n.
interface wasca_spi_sync_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        in_port;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata, in_port,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata, in_port,
    output readdata, irq
  );
endinterface

// File: rtl/wasca_spi_sync_ctrl.sv
// SPI sync strobe controller: synchronise, glitch-filter, edge detect, rise count,
// stuck-high timeout and maskable interrupt behind a 4-word Avalon-MM register file.
module wasca_spi_sync_ctrl #(
  parameter int FILTER_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  wasca_spi_sync_ctrl_if.slave  bus,
  output logic [1:0]            o_dbg_state
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOW   = 2'd1,
    S_HIGH  = 2'd2,
    S_STUCK = 2'd3
  } state_t;

  logic             r_sync1, r_sync2;
  logic             r_filt, r_filt_d;
  logic [7:0]       r_fcnt;
  logic [3:0]       r_ctrl;
  logic [2:0]       r_edge;
  logic [CNT_W-1:0] r_count;
  logic [TW-1:0]    r_tcnt;
  state_t           r_state;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic             w_wr, w_rise, w_fall, w_timeout;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_wr      = bus.chipselect & ~bus.write_n;
  assign w_rise    = r_ctrl[0] & r_filt & ~r_filt_d;
  assign w_fall    = r_ctrl[0] & ~r_filt & r_filt_d;
  // Leaving HIGH on a fall has priority over declaring the line stuck.
  assign w_timeout = r_ctrl[0] && (r_state == S_HIGH) && !w_fall
                     && (r_tcnt == TW'(TIMEOUT_CYCLES - 2));
  assign w_unused  = ^bus.writedata[31:4];

  always_comb begin
    w_rdata = 32'd0;
    case (bus.address)
      2'd0: w_rdata[3:0]       = {r_state, r_sync2, r_filt};
      2'd1: w_rdata[3:0]       = r_ctrl;
      2'd2: w_rdata[2:0]       = r_edge;
      2'd3: w_rdata[CNT_W-1:0] = r_count;
      default: w_rdata = 32'd0;
    endcase
  end

  // Input path: the filter counter tracks how long sync_lvl has disagreed with filt_lvl.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
      r_fcnt   <= 8'd0;
    end else begin
      r_sync1  <= bus.in_port;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      if (r_sync2 != r_filt) begin
        if (r_fcnt == 8'(FILTER_CYCLES - 1)) begin
          r_filt <= r_sync2;
          r_fcnt <= 8'd0;
        end else begin
          r_fcnt <= r_fcnt + 8'd1;
        end
      end else begin
        r_fcnt <= 8'd0;
      end
    end
  end

  // Register file, readback and interrupt; set beats W1C and rise beats clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl     <= 4'd0;
      r_edge     <= 3'd0;
      r_count    <= '0;
      r_readdata <= 32'd0;
      r_irq      <= 1'b0;
    end else begin
      r_readdata <= w_rdata;
      r_irq      <= |(r_edge & r_ctrl[3:1]);
      if (w_wr && bus.address == 2'd1) r_ctrl <= bus.writedata[3:0];
      if (w_wr && bus.address == 2'd2)
        r_edge <= (r_edge & ~bus.writedata[2:0]) | {w_timeout, w_fall, w_rise};
      else
        r_edge <= r_edge | {w_timeout, w_fall, w_rise};
      if (w_wr && bus.address == 2'd3) r_count <= CNT_W'(w_rise);
      else                             r_count <= r_count + CNT_W'(w_rise);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
    end else if (!r_ctrl[0]) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= r_filt ? S_HIGH : S_LOW;
          r_tcnt  <= '0;
        end
        S_LOW: begin
          if (w_rise) begin
            r_state <= S_HIGH;
            r_tcnt  <= '0;
          end
        end
        S_HIGH: begin
          if (w_fall) begin
            r_state <= S_LOW;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
            if (w_timeout) r_state <= S_STUCK;
          end
        end
        S_STUCK: begin
          if (w_fall) r_state <= S_LOW;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = r_irq;
  assign o_dbg_state  = r_state;
endmodule
